adc_scan_sequencer: RTL and testbench
=====================================

// Module: adc_scan_sequencer
// PURPOSE
// Autonomous scan controller for the 8-channel serial ADC (ADC128S022-style, 16-bit SPI frames, CPOL=1).
// Generates oCS_n/oSCLK/oDIN, captures 12-bit results and round-robins over a channel mask.
// Keeps a per-channel result register file so the LED and LCD logic can read any channel at any time.
// Replaces the single-shot, iGO-triggered conversion path with continuous sequencing from the one system clock.
// PARAMETERS
// CLK_DIV  2  iCLK cycles per SCLK half-period (>=1)
// GAP_CYC  4  minimum iCLK cycles oCS_n stays high between frames (>=2)
// PORTS
// iCLK      in   1   system clock; all logic on posedge
// iRST      in   1   asynchronous active-low reset
// iEN       in   1   scan enable (level)
// iCH_MASK  in   8   enabled channels; bit n = channel n
// iRD_CH    in   3   read-port channel select
// oRD_DATA  out  12  result register for iRD_CH (registered)
// oVALID    out  1   1-cycle strobe: new result on oCH/oDATA
// oCH       out  3   channel of the oVALID result
// oDATA     out  12  value of the oVALID result
// oBUSY     out  1   high from leaving IDLE until IDLE is re-entered
// oCS_n     out  1   ADC chip select, active low
// oSCLK     out  1   ADC serial clock, idle high
// oDIN      out  1   ADC address input
// iDOUT     in   1   ADC serial data output
// BEHAVIOUR
// Reset (async, any state): state=IDLE; oCS_n=1, oSCLK=1, oDIN=0, oVALID=0, oBUSY=0, oCH=0, oDATA=0; all 8 results=0; oRD_DATA=0 on the next edge.
// States:
// - IDLE: leaves on iEN=1 and iCH_MASK!=0.
// - SETUP: oCS_n=0 for CLK_DIV cycles.
// - XFER: 16 SCLK periods.
// - HOLD: oCS_n=0 for CLK_DIV cycles.
// - STORE: 1 cycle, oCS_n=1.
// - GAP: oCS_n=1; the STORE cycle counts toward the GAP_CYC minimum.
// - Next state after GAP: SETUP, or IDLE if iEN=0 or iCH_MASK=0.
// Frame timing:
// - oCS_n is low for exactly 34*CLK_DIV cycles.
// - Falling SCLK edge k (k=0..15) occurs at the start of SCLK period k; a rising edge follows CLK_DIV cycles later.
// - oDIN updates on falling edges. It is ADD2/ADD1/ADD0 of the addressed channel at k=2/3/4, else 0.
// - iDOUT is sampled on iCLK at each rising SCLK edge for k=4..15, MSB first, giving D11..D0.
// Pipeline: the ADC returns data for the address sent in the previous frame.
// - Each frame's result is tagged with the previous frame's address.
// - The first frame after leaving IDLE is a priming frame: its result is discarded and oVALID is not asserted.
// STORE:
// - results[tag] <= data.
// - oVALID=1, oCH=tag, oDATA=data, all for that cycle only.
// - oCH/oDATA hold their values until the next STORE.
// Address selection (at SETUP entry):
// - Pick the next set bit of iCH_MASK strictly after the last addressed channel, ascending with wrap 7->0.
// - After IDLE, the search starts from channel 7, so channel 0 is first if enabled.
// - With a single enabled bit, that channel repeats.
// Mask changes:
// - A change mid-frame affects only the next address selection.
// - A result already in flight for a now-disabled channel is still stored and strobed.
// iEN falling mid-frame: the current frame completes, including STORE, then GAP, then IDLE. The address sent in that last frame is never read.
// Read port: oRD_DATA <= results[iRD_CH] every cycle; latency 1 cycle.
// - If iRD_CH equals the channel written in STORE, oRD_DATA shows the old value that cycle and the new value on the next cycle.
// oBUSY=1 in every non-IDLE state.
// TESTING
// - Reset mid-XFER (CLK_DIV=2): assert iRST low while oSCLK=0 -> oCS_n=1 and oSCLK=1 immediately; oBUSY=0; oRD_DATA=0 for all 8 channels.
// - Single channel: iCH_MASK=8'h20, iEN=1, ADC model returns 12'hA5C -> first frame has no oVALID; each later frame gives oVALID with oCH=5, oDATA=12'hA5C; oDIN=1,0,1 at k=2,3,4.
// - Round-robin: iCH_MASK=8'h91, model returns 12'h100+ch -> oCH sequence 0,4,7,0,4; oDATA=12'h100,12'h104,12'h107,...
// - Timing (CLK_DIV=2, GAP_CYC=4): oCS_n low exactly 68 cycles per frame and high at least 4 cycles between frames; exactly 16 oSCLK falling edges per frame.
// - iEN drops at k=8 while addressing channel 3 with prior tag 2 -> the frame finishes; oVALID with oCH=2; then IDLE; results[3] unchanged.
// - iCH_MASK=0 with iEN=1 -> stays in IDLE; oCS_n=1; oBUSY=0. Setting iCH_MASK=8'h02 -> SETUP on the next cycle.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Continuous round-robin scan controller for an 8-channel 16-bit-frame SPI ADC
// (CPOL=1). It keeps a per-channel result register file with a registered read port.
module adc_scan_sequencer #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [7:0]  iCH_MASK,
  input  logic [2:0]  iRD_CH,
  output logic [11:0] oRD_DATA,
  output logic        oVALID,
  output logic [2:0]  oCH,
  output logic [11:0] oDATA,
  output logic        oBUSY,
  output logic        oCS_n,
  output logic        oSCLK,
  output logic        oDIN,
  input  logic        iDOUT
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, STORE, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_k;
  logic             hi;
  logic [2:0]       addr, tag;
  logic             primed;
  logic [11:0]      shift;
  logic [11:0]      results [8];

  logic       div_end, gap_end, go;
  logic       fall_evt, rise_evt, store_evt, setup_entry;
  logic [3:0] k_fall;
  logic [2:0] search_from;

  // Next enabled channel strictly after 'last', ascending with wrap; i=8 lands
  // back on 'last' so a single enabled channel repeats.
  function automatic logic [2:0] next_ch(input logic [2:0] last, input logic [7:0] mask);
    logic [2:0] r;
    logic [2:0] c;
    logic       found;
    r     = last;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      c = last + i[2:0];
      if (!found && mask[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Address bit presented on DIN for SCLK period k (ADD2..ADD0 at k=2..4).
  function automatic logic din_bit(input logic [3:0] k, input logic [2:0] a);
    case (k)
      4'd2:    din_bit = a[2];
      4'd3:    din_bit = a[1];
      4'd4:    din_bit = a[0];
      default: din_bit = 1'b0;
    endcase
  endfunction

  assign div_end     = (cnt == CNT_W'(CLK_DIV - 1));
  assign gap_end     = (cnt == CNT_W'(GAP_CYC - 2));
  assign go          = iEN && (iCH_MASK != 8'h00);
  assign rise_evt    = (state == XFER) && div_end && !hi;
  assign fall_evt    = ((state == SETUP) && div_end) ||
                       ((state == XFER) && div_end && hi && (bit_k != 4'd15));
  assign k_fall      = (state == SETUP) ? 4'd0 : bit_k + 4'd1;
  assign store_evt   = (state == HOLD) && (state_nxt == STORE) && primed;
  assign setup_entry = (state_nxt == SETUP) && (state != SETUP);
  // Coming out of IDLE the search restarts from 7 so channel 0 is tried first.
  assign search_from = (state == IDLE) ? 3'd7 : addr;

  // Next-state logic; the STORE cycle already counts as one gap cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = SETUP;
      SETUP:   if (div_end) state_nxt = XFER;
      XFER:    if (div_end && hi && (bit_k == 4'd15)) state_nxt = HOLD;
      HOLD:    if (div_end) state_nxt = STORE;
      STORE:   state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = go ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase counter plus SCLK half-period / bit-index tracking during XFER.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt   <= '0;
      bit_k <= 4'd0;
      hi    <= 1'b0;
    end else begin
      if ((state == IDLE) || (state_nxt != state) || ((state == XFER) && div_end))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (state != XFER) begin
        bit_k <= 4'd0;
        hi    <= 1'b0;
      end else if (div_end) begin
        hi <= !hi;
        if (hi) bit_k <= bit_k + 4'd1;
      end
    end
  end

  // State register, address/tag bookkeeping and registered ADC pins.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state  <= IDLE;
      addr   <= 3'd7;
      tag    <= 3'd0;
      primed <= 1'b0;
      oCS_n  <= 1'b1;
      oSCLK  <= 1'b1;
      oDIN   <= 1'b0;
      oBUSY  <= 1'b0;
      oVALID <= 1'b0;
    end else begin
      state  <= state_nxt;
      oCS_n  <= !(state_nxt inside {SETUP, XFER, HOLD});
      oBUSY  <= (state_nxt != IDLE);
      oVALID <= store_evt;
      if (setup_entry) begin
        tag    <= addr;
        addr   <= next_ch(search_from, iCH_MASK);
        primed <= (state == GAP);
      end
      if (fall_evt) begin
        oSCLK <= 1'b0;
        oDIN  <= din_bit(k_fall, addr);
      end else if (rise_evt) begin
        oSCLK <= 1'b1;
      end
    end
  end

  // Result capture: iDOUT sampled on rising SCLK for k=4..15, MSB first.
  always_ff @(posedge iCLK) begin
    if (rise_evt && (bit_k >= 4'd4)) shift <= {shift[10:0], iDOUT};
  end

  // Result file and strobe data, written as the frame enters STORE.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oCH   <= 3'd0;
      oDATA <= 12'd0;
      for (int i = 0; i < 8; i++) results[i] <= 12'd0;
    end else if (store_evt) begin
      results[tag] <= shift;
      oCH          <= tag;
      oDATA        <= shift;
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge iCLK) begin
    oRD_DATA <= results[iRD_CH];
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Scoreboard bench for adc_scan_sequencer with a behavioural serial ADC model.
module tb_adc_scan_sequencer;

  localparam int CLK_DIV = 2;
  localparam int GAP_CYC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  mask = 8'h00;
  logic [2:0]  rd_ch = 3'd0;
  logic        dout = 1'b0;
  logic [11:0] rd_data;
  logic        valid;
  logic [2:0]  och;
  logic [11:0] odata;
  logic        busy, cs_n, sclk, din;

  adc_scan_sequencer #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .iCLK(clk), .iRST(rst_n), .iEN(en), .iCH_MASK(mask), .iRD_CH(rd_ch),
    .oRD_DATA(rd_data), .oVALID(valid), .oCH(och), .oDATA(odata), .oBUSY(busy),
    .oCS_n(cs_n), .oSCLK(sclk), .oDIN(din), .iDOUT(dout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {logic [2:0] ch; logic [11:0] data;} res_t;

  res_t        sb[$];
  res_t        e;
  logic [2:0]  addr_log[$];
  logic [2:0]  ch_log[$];
  logic [11:0] data_log[$];
  logic [11:0] rd_at_strobe[$];
  logic [11:0] rd_after_strobe[$];
  int          frames_started = 0, frames_done = 0;
  int          fall_cnt = 0, lo_cnt = 0, hi_cnt = 0, idx;
  logic        in_frame = 0, seen_frame = 0, have_prev = 0, rd_watch = 0;
  logic        cs_q = 1, sclk_q = 1;
  logic [2:0]  prev_addr = 0, addr_sh = 0;
  logic [11:0] cur_data = 0;
  int          mode = 0;

  // ADC model + frame monitor + scoreboard, all sampled on the falling clock edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      in_frame = 0; seen_frame = 0; have_prev = 0; rd_watch = 0;
      cs_q = 1; sclk_q = 1; dout = 0; hi_cnt = 0;
    end else begin
      if (rd_watch) begin
        rd_after_strobe.push_back(rd_data);
        rd_watch = 0;
      end
      if (valid) begin
        rd_at_strobe.push_back(rd_data);
        rd_watch = 1;
        ch_log.push_back(och);
        data_log.push_back(odata);
        if (sb.size() == 0) chk("valid_with_empty_sb", valid, 0);
        else begin
          e = sb.pop_front();
          chk("valid_ch", och, e.ch);
          chk("valid_data", odata, e.data);
        end
      end
      if (cs_q && !cs_n) begin
        if (seen_frame) chk("gap_min", hi_cnt >= GAP_CYC, 1);
        in_frame = 1; frames_started++;
        lo_cnt = 0; fall_cnt = 0; addr_sh = 0;
        cur_data = (mode == 0) ? 12'hA5C : (12'h100 | {9'd0, prev_addr});
        if (have_prev) sb.push_back({prev_addr, cur_data});
      end
      if (!cs_n) begin
        lo_cnt++;
        if (sclk_q && !sclk) begin
          if (fall_cnt >= 4) begin
            idx  = 15 - fall_cnt;
            dout = cur_data[idx];
          end else dout = 0;
          fall_cnt++;
        end
        if (!sclk_q && sclk && fall_cnt >= 3 && fall_cnt <= 5) addr_sh = {addr_sh[1:0], din};
      end
      if (!cs_q && cs_n && in_frame) begin
        chk("cs_low_len", lo_cnt, 34 * CLK_DIV);
        chk("sclk_falls", fall_cnt, 16);
        addr_log.push_back(addr_sh);
        prev_addr = addr_sh; have_prev = 1;
        in_frame = 0; seen_frame = 1; frames_done++; hi_cnt = 0;
      end
      if (cs_n) hi_cnt++;
      if (!busy) have_prev = 0;
      cs_q = cs_n; sclk_q = sclk;
    end
  end

  task automatic clear_logs();
    addr_log.delete(); ch_log.delete(); data_log.delete();
    rd_at_strobe.delete(); rd_after_strobe.delete();
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_valids(input int n, input int budget, input string tag);
    int c = 0;
    while (ch_log.size() < n && c < budget) begin step(); c++; end
    if (ch_log.size() < n) chk(tag, ch_log.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    while (busy && c < budget) begin step(); c++; end
    if (busy) chk(tag, busy, 0);
  endtask

  int exp_rr[5] = '{0, 4, 7, 0, 4};
  int fs0, fd0, c;

  initial begin
    repeat (3) step();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_din", din, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ch", och, 0);
    chk("rst_data", odata, 0);
    chk("rst_rd", rd_data, 0);
    rst_n = 1;

    // Empty mask keeps the sequencer idle; a non-empty mask starts it next cycle.
    en = 1; mask = 8'h00;
    repeat (10) step();
    chk("idle_busy", busy, 0);
    chk("idle_cs_n", cs_n, 1);
    mask = 8'h02;
    @(posedge clk); #1;
    chk("go_busy", busy, 1);
    chk("go_cs_n", cs_n, 0);
    en = 0;
    wait_idle(300, "idle_timeout_a");

    // Single channel: channel 5 repeats, first frame is priming only.
    clear_logs();
    mode = 0; mask = 8'h20; rd_ch = 3'd5; en = 1;
    fd0 = frames_done; c = 0;
    while (frames_done == fd0 && c < 200) begin step(); c++; end
    repeat (4) step();
    chk("prime_no_valid", ch_log.size(), 0);
    wait_valids(3, 400, "single_timeout");
    for (int i = 0; i < 3; i++) begin
      chk("single_ch", ch_log[i], 5);
      chk("single_data", data_log[i], 12'hA5C);
      chk("single_addr", addr_log[i], 5);
    end
    chk("rd_old_at_strobe", rd_at_strobe[0], 12'h000);
    chk("rd_new_after", rd_after_strobe[0], 12'hA5C);
    chk("rd_ch5", rd_data, 12'hA5C);

    // Asynchronous reset while SCLK is low.
    c = 0;
    while (sclk && c < 200) begin step(); c++; end
    chk("sclk_low_before_rst", sclk, 0);
    rst_n = 0; #1;
    chk("arst_cs_n", cs_n, 1);
    chk("arst_sclk", sclk, 1);
    chk("arst_busy", busy, 0);
    chk("arst_valid", valid, 0);
    en = 0;
    repeat (2) step();
    rst_n = 1;
    for (int ch = 0; ch < 8; ch++) begin
      rd_ch = 3'(ch);
      step();
      chk("arst_rd", rd_data, 12'h000);
    end

    // Round-robin over channels 0, 4, 7.
    clear_logs();
    mode = 1; mask = 8'h91; en = 1;
    wait_valids(5, 1000, "rr_timeout");
    en = 0;
    for (int i = 0; i < 5; i++) begin
      chk("rr_ch", ch_log[i], exp_rr[i]);
      chk("rr_data", data_log[i], 12'h100 + exp_rr[i]);
    end
    wait_idle(300, "idle_timeout_b");

    // iEN drops at k=8 of the frame addressing channel 3 (tag 2).
    clear_logs();
    mode = 1; mask = 8'h0C; rd_ch = 3'd3; en = 1;
    fs0 = frames_started; c = 0;
    while (!(frames_started == fs0 + 2 && fall_cnt >= 9) && c < 400) begin step(); c++; end
    chk("reach_k8", frames_started - fs0, 2);
    en = 0;
    wait_idle(300, "idle_timeout_c");
    repeat (4) step();
    chk("drop_nvalid", ch_log.size(), 1);
    chk("drop_ch", ch_log[0], 2);
    chk("drop_data", data_log[0], 12'h102);
    chk("drop_addr_last", addr_log[1], 3);
    chk("drop_frames", frames_started - fs0, 2);
    chk("drop_rd_ch3", rd_data, 12'h000);
    rd_ch = 3'd2;
    step();
    chk("drop_rd_ch2", rd_data, 12'h102);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
